// File: rtl/mem_arbiter_if.sv
// Bundle of the two master ports and the shared memory port seen by mem_arbiter.
// The arbiter connects through the slave modport; a requester/memory model uses master.
interface mem_arbiter_if;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wmask;
    logic        m0_rstrb;
    logic        m0_wait;
    logic [31:0] m0_rdata;
    logic        m0_rvalid;

    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wmask;
    logic        m1_rstrb;
    logic        m1_wait;
    logic [31:0] m1_rdata;
    logic        m1_rvalid;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;

    modport slave (
        input  m0_addr, m0_wdata, m0_wmask, m0_rstrb,
        input  m1_addr, m1_wdata, m1_wmask, m1_rstrb,
        input  mem_rdata,
        output m0_wait, m0_rdata, m0_rvalid,
        output m1_wait, m1_rdata, m1_rvalid,
        output mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );

    modport master (
        output m0_addr, m0_wdata, m0_wmask, m0_rstrb,
        output m1_addr, m1_wdata, m1_wmask, m1_rstrb,
        output mem_rdata,
        input  m0_wait, m0_rdata, m0_rvalid,
        input  m1_wait, m1_rdata, m1_rvalid,
        input  mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port memory with 1-cycle read latency.
// Grants are combinational; the read owner is remembered for one cycle so the
// returning mem_rdata is steered to the right master.
module mem_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    logic        req0, req1;
    logic        gnt0, gnt1;
    logic        mem_rstrb;
    logic        last_grant_q, last_grant_d;  // 1 = master 1 was granted most recently
    logic        pend_valid_q, pend_valid_d;
    logic        pend_owner_q, pend_owner_d;
    logic        m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    assign req0 = bus.m0_rstrb | (|bus.m0_wmask);
    assign req1 = bus.m1_rstrb | (|bus.m1_wmask);

    // Pick at most one master per cycle; nobody is granted while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                if ((FIXED_PRIO != 0) || last_grant_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Steer the granted master onto the memory port; a write wins over a read.
    always_comb begin
        bus.mem_addr  = bus.m0_addr;
        bus.mem_wdata = bus.m0_wdata;
        bus.mem_wmask = 4'h0;
        mem_rstrb     = 1'b0;
        if (gnt0) begin
            bus.mem_wmask = bus.m0_wmask;
            mem_rstrb     = bus.m0_rstrb & ~(|bus.m0_wmask);
        end else if (gnt1) begin
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
            bus.mem_wmask = bus.m1_wmask;
            mem_rstrb     = bus.m1_rstrb & ~(|bus.m1_wmask);
        end
        bus.mem_rstrb = mem_rstrb;
        bus.m0_wait   = req0 & ~gnt0 & ~reset;
        bus.m1_wait   = req1 & ~gnt1 & ~reset;
    end

    // Next-state for grant history and read return; rdata passes through in the rvalid cycle.
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0) begin
            last_grant_d = 1'b0;
        end else if (gnt1) begin
            last_grant_d = 1'b1;
        end
        pend_valid_d  = mem_rstrb;
        pend_owner_d  = gnt1;
        m0_rvalid     = pend_valid_q & ~pend_owner_q & ~reset;
        m1_rvalid     = pend_valid_q & pend_owner_q & ~reset;
        m0_rdata_d    = m0_rvalid ? bus.mem_rdata : m0_rdata_q;
        m1_rdata_d    = m1_rvalid ? bus.mem_rdata : m1_rdata_q;
        bus.m0_rvalid = m0_rvalid;
        bus.m1_rvalid = m1_rvalid;
        bus.m0_rdata  = reset ? 32'h0 : m0_rdata_d;
        bus.m1_rdata  = reset ? 32'h0 : m1_rdata_d;
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_owner_q <= 1'b0;
            m0_rdata_q   <= 32'h0;
            m1_rdata_q   <= 32'h0;
        end else begin
            last_grant_q <= last_grant_d;
            pend_valid_q <= pend_valid_d;
            pend_owner_q <= pend_owner_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share one
// stimulus stream, each with its own memory and its own behavioural model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] a0, a1, wd0, wd1;
    logic [3:0]  wm0, wm1;
    logic        rs0, rs1;

    int total = 0;
    int bad   = 0;

    mem_arbiter_if bus_rr ();
    mem_arbiter_if bus_fp ();

    mem_arbiter #(.FIXED_PRIO(0)) dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));
    mem_arbiter #(.FIXED_PRIO(1)) dut_fp (.clk(clk), .reset(reset), .bus(bus_fp));

    assign bus_rr.m0_addr  = a0;
    assign bus_rr.m0_wdata = wd0;
    assign bus_rr.m0_wmask = wm0;
    assign bus_rr.m0_rstrb = rs0;
    assign bus_rr.m1_addr  = a1;
    assign bus_rr.m1_wdata = wd1;
    assign bus_rr.m1_wmask = wm1;
    assign bus_rr.m1_rstrb = rs1;
    assign bus_fp.m0_addr  = a0;
    assign bus_fp.m0_wdata = wd0;
    assign bus_fp.m0_wmask = wm0;
    assign bus_fp.m0_rstrb = rs0;
    assign bus_fp.m1_addr  = a1;
    assign bus_fp.m1_wdata = wd1;
    assign bus_fp.m1_wmask = wm1;
    assign bus_fp.m1_rstrb = rs1;

    // Memories: one per instance, 1-cycle read latency.
    logic [31:0] ram [2][256];
    logic [31:0] mrd [2];
    assign bus_rr.mem_rdata = mrd[0];
    assign bus_fp.mem_rdata = mrd[1];

    always @(posedge clk) begin
        if (bus_rr.mem_rstrb) mrd[0] <= ram[0][bus_rr.mem_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (bus_rr.mem_wmask[b])
                ram[0][bus_rr.mem_addr[9:2]][8*b +: 8] <= bus_rr.mem_wdata[8*b +: 8];
    end

    always @(posedge clk) begin
        if (bus_fp.mem_rstrb) mrd[1] <= ram[1][bus_fp.mem_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (bus_fp.mem_wmask[b])
                ram[1][bus_fp.mem_addr[9:2]][8*b +: 8] <= bus_fp.mem_wdata[8*b +: 8];
    end

    // DUT outputs gathered per instance (k=0 round-robin, k=1 fixed priority).
    logic        o_w0 [2], o_w1 [2], o_v0 [2], o_v1 [2], o_mrs [2];
    logic [31:0] o_d0 [2], o_d1 [2], o_ma [2], o_mwd [2];
    logic [3:0]  o_mwm [2];
    assign o_w0[0] = bus_rr.m0_wait;    assign o_w0[1] = bus_fp.m0_wait;
    assign o_w1[0] = bus_rr.m1_wait;    assign o_w1[1] = bus_fp.m1_wait;
    assign o_v0[0] = bus_rr.m0_rvalid;  assign o_v0[1] = bus_fp.m0_rvalid;
    assign o_v1[0] = bus_rr.m1_rvalid;  assign o_v1[1] = bus_fp.m1_rvalid;
    assign o_d0[0] = bus_rr.m0_rdata;   assign o_d0[1] = bus_fp.m0_rdata;
    assign o_d1[0] = bus_rr.m1_rdata;   assign o_d1[1] = bus_fp.m1_rdata;
    assign o_ma[0] = bus_rr.mem_addr;   assign o_ma[1] = bus_fp.mem_addr;
    assign o_mwd[0] = bus_rr.mem_wdata; assign o_mwd[1] = bus_fp.mem_wdata;
    assign o_mwm[0] = bus_rr.mem_wmask; assign o_mwm[1] = bus_fp.mem_wmask;
    assign o_mrs[0] = bus_rr.mem_rstrb; assign o_mrs[1] = bus_fp.mem_rstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: who won last, which master owns the read in flight, what it will return.
    int          m_last [2];
    int          m_pend [2];
    logic [31:0] m_pend_data [2];
    logic [31:0] m_rdata [2][2];
    logic [31:0] ref_mem [2][256];

    task automatic model_step(input int k);
        logic        r0, r1, e_rs;
        int          g;
        logic [31:0] e_a, e_wd;
        logic [3:0]  e_wm;
        logic        e_rv [2];
        logic [31:0] e_rd [2];
        string       p;
        p  = (k == 0) ? "rr" : "fp";
        r0 = rs0 || (wm0 != 4'h0);
        r1 = rs1 || (wm1 != 4'h0);
        if (reset)          g = -1;
        else if (r0 && r1)  g = (k == 1) ? 0 : ((m_last[k] == 0) ? 1 : 0);
        else if (r0)        g = 0;
        else if (r1)        g = 1;
        else                g = -1;
        e_a  = (g == 1) ? a1 : a0;
        e_wd = (g == 1) ? wd1 : wd0;
        e_wm = (g == 0) ? wm0 : (g == 1) ? wm1 : 4'h0;
        e_rs = (g == 0 && rs0 && wm0 == 4'h0) || (g == 1 && rs1 && wm1 == 4'h0);
        for (int i = 0; i < 2; i++) begin
            e_rv[i] = !reset && (m_pend[k] == i);
            e_rd[i] = reset ? 32'h0 : (e_rv[i] ? m_pend_data[k] : m_rdata[k][i]);
        end
        chk({p, " m0_wait"},   32'(o_w0[k]), 32'(!reset && r0 && g != 0));
        chk({p, " m1_wait"},   32'(o_w1[k]), 32'(!reset && r1 && g != 1));
        chk({p, " mem_wmask"}, 32'(o_mwm[k]), 32'(e_wm));
        chk({p, " mem_rstrb"}, 32'(o_mrs[k]), 32'(e_rs));
        chk({p, " mem_addr"},  o_ma[k], e_a);
        chk({p, " mem_wdata"}, o_mwd[k], e_wd);
        chk({p, " m0_rvalid"}, 32'(o_v0[k]), 32'(e_rv[0]));
        chk({p, " m1_rvalid"}, 32'(o_v1[k]), 32'(e_rv[1]));
        chk({p, " m0_rdata"},  o_d0[k], e_rd[0]);
        chk({p, " m1_rdata"},  o_d1[k], e_rd[1]);
        if (reset) begin
            m_last[k]     = 1;
            m_pend[k]     = -1;
            m_rdata[k][0] = 32'h0;
            m_rdata[k][1] = 32'h0;
        end else begin
            if (m_pend[k] >= 0) m_rdata[k][m_pend[k]] = m_pend_data[k];
            m_pend[k] = e_rs ? g : -1;
            if (e_rs) m_pend_data[k] = ref_mem[k][e_a[9:2]];
            for (int b = 0; b < 4; b++)
                if (e_wm[b]) ref_mem[k][e_a[9:2]][8*b +: 8] = e_wd[8*b +: 8];
            if (g >= 0) m_last[k] = g;
        end
    endtask

    // Every cycle, away from the clock edge, compare both instances against the model.
    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic apply(input logic [31:0] xa0, input logic [31:0] xwd0, input logic [3:0] xwm0,
                         input logic xrs0, input logic [31:0] xa1, input logic [31:0] xwd1,
                         input logic [3:0] xwm1, input logic xrs1, input logic xrst);
        @(posedge clk);
        #1;
        a0 = xa0; wd0 = xwd0; wm0 = xwm0; rs0 = xrs0;
        a1 = xa1; wd1 = xwd1; wm1 = xwm1; rs1 = xrs1;
        reset = xrst;
        @(negedge clk);
    endtask

    task automatic idle(input logic xrst);
        apply(32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, xrst);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_last[k] = 1;
            m_pend[k] = -1;
            m_pend_data[k] = 32'h0;
            m_rdata[k][0] = 32'h0;
            m_rdata[k][1] = 32'h0;
            for (int w = 0; w < 256; w++) ref_mem[k][w] = 32'h0;
        end
        reset = 1'b1;
        a0 = 32'h0; wd0 = 32'h0; wm0 = 4'h0; rs0 = 1'b0;
        a1 = 32'h0; wd1 = 32'h0; wm1 = 4'h0; rs1 = 1'b0;

        idle(1'b1);
        idle(1'b1);
        chk("reset m0_rdata", bus_rr.m0_rdata, 32'h0);
        chk("reset m0_rvalid", 32'(bus_rr.m0_rvalid), 32'h0);

        // m0 full-word write then read back
        apply(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("wr m0_wait", 32'(bus_rr.m0_wait), 32'h0);
        chk("wr mem_wmask", 32'(bus_rr.mem_wmask), 32'hF);
        apply(32'h10, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("rd mem_rstrb", 32'(bus_rr.mem_rstrb), 32'h1);
        idle(1'b0);
        chk("rd m0_rvalid", 32'(bus_rr.m0_rvalid), 32'h1);
        chk("rd m0_rdata", bus_rr.m0_rdata, 32'hDEADBEEF);
        idle(1'b0);
        chk("hold m0_rvalid", 32'(bus_rr.m0_rvalid), 32'h0);
        chk("hold m0_rdata", bus_rr.m0_rdata, 32'hDEADBEEF);

        // m1 byte-lane write into an existing word
        apply(32'h0, 32'h0, 4'h0, 1'b0, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0);
        apply(32'h0, 32'h0, 4'h0, 1'b0, 32'h20, 32'h0000AB00, 4'h2, 1'b0, 1'b0);
        apply(32'h0, 32'h0, 4'h0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0);
        idle(1'b0);
        chk("byte m1_rvalid", 32'(bus_rr.m1_rvalid), 32'h1);
        chk("byte m1_rdata rr", bus_rr.m1_rdata, 32'h1122AB44);
        chk("byte m1_rdata fp", bus_fp.m1_rdata, 32'h1122AB44);

        // read strobe together with write mask: write only
        apply(32'h30, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("rw mem_rstrb", 32'(bus_rr.mem_rstrb), 32'h0);
        idle(1'b0);
        chk("rw m0_rvalid", 32'(bus_rr.m0_rvalid), 32'h0);
        chk("rw m0_rdata", bus_rr.m0_rdata, 32'hDEADBEEF);
        apply(32'h30, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        idle(1'b0);
        chk("rw readback", bus_rr.m0_rdata, 32'hCAFEF00D);

        // read in flight killed by reset
        apply(32'h10, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        idle(1'b1);
        chk("kill rvalid 1", 32'(bus_rr.m0_rvalid), 32'h0);
        chk("kill rdata 1", bus_rr.m0_rdata, 32'h0);
        idle(1'b1);
        chk("kill rdata 2", bus_rr.m0_rdata, 32'h0);
        idle(1'b0);
        chk("kill rvalid post", 32'(bus_rr.m0_rvalid), 32'h0);
        chk("kill rdata post", bus_rr.m0_rdata, 32'h0);

        // both masters read continuously
        for (int i = 0; i < 8; i++) begin
            apply(32'h10, 32'h0, 4'h0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0);
            chk($sformatf("rr m0_wait c%0d", i), 32'(bus_rr.m0_wait), 32'(i % 2));
            chk($sformatf("rr m1_wait c%0d", i), 32'(bus_rr.m1_wait), 32'((i + 1) % 2));
            chk($sformatf("rr m0_rvalid c%0d", i), 32'(bus_rr.m0_rvalid),
                32'(i >= 1 && (i % 2) == 1));
            chk($sformatf("rr m1_rvalid c%0d", i), 32'(bus_rr.m1_rvalid),
                32'(i >= 2 && (i % 2) == 0));
            chk($sformatf("fp m1_wait c%0d", i), 32'(bus_fp.m1_wait), 32'h1);
            chk($sformatf("fp m1_rvalid c%0d", i), 32'(bus_fp.m1_rvalid), 32'h0);
            chk($sformatf("fp m0_rvalid c%0d", i), 32'(bus_fp.m0_rvalid), 32'(i >= 1));
            if (i >= 1) chk($sformatf("fp m0_rdata c%0d", i), bus_fp.m0_rdata, 32'hDEADBEEF);
        end
        idle(1'b0);
        idle(1'b0);
        chk("end rr m1_rdata", bus_rr.m1_rdata, 32'h1122AB44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = master 0 always wins a conflict.
REQ-002 SHALL provide port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL provide ports m0_addr / m1_addr, input, 32, master byte address.
REQ-005 SHALL provide ports m0_wdata / m1_wdata, input, 32, master write data.
REQ-006 SHALL provide ports m0_wmask / m1_wmask, input, 4, master byte write enables.
REQ-007 SHALL provide ports m0_rstrb / m1_rstrb, input, 1, master read strobe.
REQ-008 SHALL provide ports m0_wait / m1_wait, output, 1, request present but not granted this cycle.
REQ-009 SHALL provide ports m0_rdata / m1_rdata, output, 32, last read data returned to that master.
REQ-010 SHALL provide ports m0_rvalid / m1_rvalid, output, 1, one-cycle pulse when mN_rdata updates.
REQ-011 SHALL provide ports mem_addr, mem_wdata, mem_wmask, mem_rstrb, output, 32/32/4/1, to the shared memory.
REQ-012 SHALL provide port mem_rdata, input, 32, memory read data, valid the cycle after mem_rstrb.

Function
REQ-013 SHALL treat master N as requesting when mN_rstrb=1 or mN_wmask!=0; both set = write only, no read, no rvalid.
REQ-014 SHALL arbitrate combinationally each cycle; exactly one requester granted per cycle, none if no request.
REQ-015 SHALL grant the sole requester when only one master requests.
REQ-016 SHALL, on conflict with FIXED_PRIO=0, grant the master not granted most recently (last_grant register), then update last_grant.
REQ-017 SHALL, on conflict with FIXED_PRIO=1, grant master 0; last_grant still tracks grants.
REQ-018 SHALL drive mem_addr/mem_wdata/mem_wmask/mem_rstrb from the granted master in the same cycle; writes commit at that clock edge.
REQ-019 SHALL, when no grant, drive mem_rstrb=0, mem_wmask=0, mem_addr=m0_addr, mem_wdata=m0_wdata.
REQ-020 SHALL assert mN_wait=1 exactly when master N requests and is not granted; master holds request stable while waiting.
REQ-021 SHALL record the read owner in a pending register at a read-grant edge; next cycle capture mem_rdata into that master's rdata register and pulse its rvalid for one cycle.
REQ-022 SHALL allow back-to-back reads (new grant in the same cycle a prior read returns); read latency fixed at 1 cycle after grant, no gaps.
REQ-023 SHALL hold mN_rdata unchanged between that master's rvalid pulses.
REQ-024 SHALL never assert m0_rvalid and m1_rvalid in the same cycle.
REQ-025 SHALL bound starvation under FIXED_PRIO=0: a continuously requesting master is granted within 2 cycles.

Reset
REQ-026 SHALL, while reset=1, clear last_grant to 1 (master 0 wins first conflict), clear pending read, drive m0/m1_rvalid=0, m0/m1_rdata=0.
REQ-027 SHALL suppress memory access while reset=1: mem_rstrb=0, mem_wmask=0, mN_wait=0.
REQ-028 SHALL discard a read in flight when reset asserts mid-operation; no rvalid issued after reset release for it.

Verification
REQ-029 SHALL cover: m0 write addr 0x10 data 0xDEADBEEF mask 0xF alone, then m0 read 0x10 -> m0_wait=0, m0_rvalid 1 cycle after grant, m0_rdata=0xDEADBEEF.
REQ-030 SHALL cover: m0 and m1 both read continuously after reset, FIXED_PRIO=0 -> grants alternate 0,1,0,1; each rvalid pulse every other cycle; waits alternate.
REQ-031 SHALL cover: same stimulus with FIXED_PRIO=1 -> m0 granted every cycle, m1_wait=1 throughout, m1_rvalid never.
REQ-032 SHALL cover: m1 byte write mask 0x2 data 0x0000AB00 to word holding 0x11223344 -> readback 0x1122AB44.
REQ-033 SHALL cover: m0 read granted, reset asserted next cycle for 2 cycles -> no rvalid, rdata=0, first post-reset conflict granted to m0.
REQ-034 SHALL cover: m0 rstrb=1 and wmask=0xF simultaneously -> write performed, m0_rvalid stays 0.
